adc_trigger_sequencer: RTL and testbench

// Upstream of the ADC capture FIFO, in the adc_sampleclk domain. Keeps a programmable pre-trigger history of ADC samples.
// On a trigger edge it streams delayed samples downstream, driving adc_capture_go / adc_write_mask, for exactly samples_i valid beats.

---
 rtl/adc_trigger_sequencer_pkg.sv | 18 +
 rtl/adc_trigger_sequencer_delay.sv | 37 +++
 rtl/adc_trigger_sequencer.sv | 116 +++++++++++
 tb/tb_adc_trigger_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_trigger_sequencer_pkg.sv
// rtl/adc_trigger_sequencer_pkg.sv - shared state encodings and defaults for the ADC trigger sequencer
package adc_trigger_sequencer_pkg;

  localparam int DEFAULT_PRE_DEPTH = 64;

  localparam logic [1:0] ENC_IDLE      = 2'd0;
  localparam logic [1:0] ENC_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ENC_CAPTURE   = 2'd2;
  localparam logic [1:0] ENC_DONE      = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ENC_IDLE,
    WAIT_TRIG = ENC_WAIT_TRIG,
    CAPTURE   = ENC_CAPTURE,
    DONE      = ENC_DONE
  } seq_state_e;

endpackage

// File: rtl/adc_trigger_sequencer_delay.sv
// rtl/adc_trigger_sequencer_delay.sv - circular history RAM giving a programmable sample delay
module adc_presample_delay
  import adc_trigger_sequencer_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = DEFAULT_PRE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic [AW-1:0]     delay,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_addr;

  assign rd_addr = wr_ptr - delay;

  always_ff @(posedge clk) begin
    mem[wr_ptr] <= din;
  end

  // Zero delay reads the slot being written this cycle, so bypass the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + 1'b1;
      dout   <= (delay == '0) ? din : mem[rd_addr];
    end
  end

endmodule

// File: rtl/adc_trigger_sequencer.sv
// rtl/adc_trigger_sequencer.sv - arm/trigger sequencer streaming pre-trigger history to the capture FIFO
module adc_trigger_sequencer
  import adc_trigger_sequencer_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int PRE_DEPTH = DEFAULT_PRE_DEPTH,
  parameter int CNT_W     = 32
) (
  input  logic                         adc_sampleclk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            adc_datain,
  input  logic                         arm_i,
  input  logic                         trig_i,
  input  logic [$clog2(PRE_DEPTH)-1:0] presamples_i,
  input  logic [CNT_W-1:0]             samples_i,
  input  logic                         capture_stop_i,
  output logic [DATA_W-1:0]            adc_data_o,
  output logic                         adc_capture_go_o,
  output logic                         adc_write_mask_o,
  output logic                         armed_o,
  output logic                         capture_done_o,
  output logic                         presample_short_o
);

  localparam int PW = $clog2(PRE_DEPTH);

  seq_state_e       state, state_next;
  logic             arm_d, trig_d;
  logic             arm_edge, arm_lost, trig_edge;
  logic [PW-1:0]    pre_l, fill_ctr, fill_next, stale_ctr;
  logic [CNT_W-1:0] num_l, rem_ctr;
  logic             short_q, is_short;

  assign arm_edge  = arm_i & ~arm_d;
  assign arm_lost  = ~arm_i & ~arm_d;
  assign trig_edge = trig_i & ~trig_d;
  // fill_next includes the trigger cycle's own sample
  assign fill_next = (fill_ctr == PW'(PRE_DEPTH - 1)) ? fill_ctr : fill_ctr + 1'b1;
  assign is_short  = fill_next < pre_l;

  adc_presample_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (PRE_DEPTH)
  ) u_delay (
    .clk     (adc_sampleclk),
    .reset_n (reset_n),
    .din     (adc_datain),
    .delay   (pre_l),
    .dout    (adc_data_o)
  );

  always_comb begin
    state_next = state;
    case (state)
      WAIT_TRIG: begin
        if (arm_lost)       state_next = IDLE;
        else if (trig_edge) state_next = (num_l == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (arm_lost)                                         state_next = IDLE;
        else if (capture_stop_i)                              state_next = DONE;
        else if (stale_ctr == '0 && rem_ctr == CNT_W'(1))     state_next = DONE;
      end
      default: ;
    endcase
    if (arm_edge) state_next = WAIT_TRIG;
  end

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      arm_d     <= 1'b0;
      trig_d    <= 1'b0;
      pre_l     <= '0;
      num_l     <= '0;
      fill_ctr  <= '0;
      stale_ctr <= '0;
      rem_ctr   <= '0;
      short_q   <= 1'b0;
    end else begin
      state  <= state_next;
      arm_d  <= arm_i;
      trig_d <= trig_i;
      if (arm_edge) begin
        pre_l    <= presamples_i;
        num_l    <= samples_i;
        fill_ctr <= '0;
        short_q  <= 1'b0;
      end else begin
        case (state)
          WAIT_TRIG: begin
            fill_ctr <= fill_next;
            if (!arm_lost && trig_edge) begin
              short_q   <= is_short;
              stale_ctr <= is_short ? pre_l - fill_next : '0;
              rem_ctr   <= num_l;
            end
          end
          CAPTURE: begin
            // Stale pre-arm beats are skipped without consuming the sample budget
            if (stale_ctr != '0)     stale_ctr <= stale_ctr - 1'b1;
            else if (rem_ctr != '0)  rem_ctr   <= rem_ctr - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign adc_capture_go_o  = (state == CAPTURE);
  assign adc_write_mask_o  = (state == CAPTURE) && (stale_ctr == '0);
  assign armed_o           = (state == WAIT_TRIG);
  assign capture_done_o    = (state == DONE);
  assign presample_short_o = short_q;

endmodule

// File: tb/tb_adc_trigger_sequencer.sv
// tb/tb_adc_trigger_sequencer.sv - self-checking bench for adc_trigger_sequencer
module tb_adc_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] adc_datain = '0;
  logic        arm_i, trig_i, capture_stop_i;
  logic [5:0]  presamples_i;
  logic [31:0] samples_i;
  logic [11:0] adc_data_o;
  logic        adc_capture_go_o, adc_write_mask_o, armed_o, capture_done_o, presample_short_o;

  always #5 clk = ~clk;

  adc_trigger_sequencer dut (
    .adc_sampleclk     (clk),
    .reset_n           (reset_n),
    .adc_datain        (adc_datain),
    .arm_i             (arm_i),
    .trig_i            (trig_i),
    .presamples_i      (presamples_i),
    .samples_i         (samples_i),
    .capture_stop_i    (capture_stop_i),
    .adc_data_o        (adc_data_o),
    .adc_capture_go_o  (adc_capture_go_o),
    .adc_write_mask_o  (adc_write_mask_o),
    .armed_o           (armed_o),
    .capture_done_o    (capture_done_o),
    .presample_short_o (presample_short_o)
  );

  // Behavioural model: a capture is a queue of beats built at the trigger from the arm/trigger timing.
  typedef struct { bit mask; int src; } beat_t;
  beat_t       beats[$];
  logic [11:0] hist [int];
  int  cyc = 0, valid_from = 0, m_p = 0, m_n = 0, arm_cyc = 0;
  bit  m_wait = 0, m_done = 0, m_short = 0, arm_prev = 0, trig_prev = 0;
  bit  exp_go = 0, exp_mask = 0, exp_armed = 0, exp_done = 0, exp_short = 0, exp_dval = 0;
  logic [11:0] exp_data = '0;

  function automatic logic [11:0] sample_at(input int n);
    return 12'(n * 37 + 11);
  endfunction

  always @(posedge clk) begin
    int cur, have, stale;
    bit cap;
    cur = cyc;
    cyc = cyc + 1;
    hist[cur] = adc_datain;
    if (!reset_n) begin
      beats.delete();
      m_wait = 0; m_done = 0; m_short = 0; arm_prev = 0; trig_prev = 0;
      valid_from = cur + 1;
    end else begin
      cap = beats.size() > 0;
      if (arm_i && !arm_prev) begin
        m_p = int'(presamples_i); m_n = int'(samples_i); arm_cyc = cur;
        beats.delete(); m_wait = 1; m_done = 0; m_short = 0;
      end else if ((m_wait || cap) && !arm_i && !arm_prev) begin
        beats.delete(); m_wait = 0;
      end else if (m_wait && trig_i && !trig_prev) begin
        have = (cur - arm_cyc > 63) ? 63 : cur - arm_cyc;
        m_short = have < m_p;
        stale = m_short ? m_p - have : 0;
        m_wait = 0;
        if (m_n == 0) m_done = 1;
        else begin
          for (int i = 0; i < stale; i++) beats.push_back('{0, 0});
          for (int i = 0; i < m_n; i++) beats.push_back('{1, cur - m_p + stale + i});
        end
      end else if (cap) begin
        if (capture_stop_i) beats.delete();
        else void'(beats.pop_front());
        if (beats.size() == 0) m_done = 1;
      end
      arm_prev = arm_i; trig_prev = trig_i;
    end
    exp_go    = beats.size() > 0;
    exp_mask  = exp_go && beats[0].mask;
    exp_dval  = exp_mask && beats[0].src >= valid_from && hist.exists(beats[0].src);
    exp_data  = exp_dval ? hist[beats[0].src] : '0;
    exp_armed = m_wait; exp_done = m_done; exp_short = m_short;
  end

  int n_pass = 0, n_total = 0;
  int mon_go = 0, mon_mask = 0;
  bit mon_seen = 0;
  logic [11:0] mon_first = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!capture_done_o && k < budget) begin step(); k++; end
    chk("done_reached", capture_done_o, 1);
  endtask

  initial begin
    int base_go, base_mask, tg, k;
    reset_n = 0; arm_i = 0; trig_i = 0; capture_stop_i = 0; presamples_i = 0; samples_i = 0;

    fork
      forever begin
        @(posedge clk); #2;
        adc_datain = sample_at(cyc);
      end
      forever begin
        @(negedge clk);
        if (adc_capture_go_o) mon_go++;
        if (adc_write_mask_o) mon_mask++;
        if (!adc_capture_go_o) mon_seen = 0;
        else if (adc_write_mask_o && !mon_seen) begin mon_first = adc_data_o; mon_seen = 1; end
        if (!reset_n) begin
          chk("rst_go", adc_capture_go_o, 0);  chk("rst_mask", adc_write_mask_o, 0);
          chk("rst_armed", armed_o, 0);        chk("rst_done", capture_done_o, 0);
          chk("rst_short", presample_short_o, 0); chk("rst_data", adc_data_o, 0);
        end else begin
          chk("go", adc_capture_go_o, exp_go);   chk("mask", adc_write_mask_o, exp_mask);
          chk("armed", armed_o, exp_armed);      chk("done", capture_done_o, exp_done);
          chk("short", presample_short_o, exp_short);
          if (exp_dval) chk("data", adc_data_o, exp_data);
        end
      end
    join_none

    step(3);
    reset_n = 1;
    step(2);

    // 1: P=4 N=10, long wait, later presamples change ignored
    presamples_i = 4; samples_i = 10; arm_i = 1;
    step();
    presamples_i = 9; samples_i = 3;
    step(19);
    base_go = mon_go; base_mask = mon_mask;
    trig_i = 1; tg = cyc;
    step(); trig_i = 0;
    wait_done(200);
    chk("t1_go_cycles", mon_go - base_go, 10);
    chk("t1_valid_beats", mon_mask - base_mask, 10);
    chk("t1_first_data", mon_first, sample_at(tg - 4));
    chk("t1_short", presample_short_o, 0);

    // 2: P=8 N=6, trigger 3 cycles after arm edge
    arm_i = 0; step();
    presamples_i = 8; samples_i = 6; arm_i = 1;
    step(3);
    base_go = mon_go; base_mask = mon_mask;
    trig_i = 1; tg = cyc;
    step(); trig_i = 0;
    wait_done(200);
    chk("t2_short", presample_short_o, 1);
    chk("t2_go_cycles", mon_go - base_go, 11);
    chk("t2_valid_beats", mon_mask - base_mask, 6);
    chk("t2_first_valid", mon_first, sample_at(tg - 3));

    // 3: N=0 goes straight to done
    arm_i = 0; step();
    presamples_i = 3; samples_i = 0; arm_i = 1;
    step(5);
    base_go = mon_go;
    trig_i = 1; step(); trig_i = 0; step(2);
    chk("t3_done", capture_done_o, 1);
    chk("t3_go_cycles", mon_go - base_go, 0);

    // 4: P=2 N=100, stop during beat 40
    arm_i = 0; step();
    presamples_i = 2; samples_i = 100; arm_i = 1;
    step(10);
    base_go = mon_go; base_mask = mon_mask;
    trig_i = 1; step(); trig_i = 0;
    k = 0;
    while (mon_mask - base_mask < 40 && k < 200) begin @(negedge clk); #1; k++; end
    chk("t4_reached_40", mon_mask - base_mask, 40);
    capture_stop_i = 1;
    step(); capture_stop_i = 0;
    step();
    chk("t4_done", capture_done_o, 1);
    chk("t4_valid_beats", mon_mask - base_mask, 40);
    chk("t4_go_cycles", mon_go - base_go, 40);

    // 5: async reset mid-capture, then trigger without arm
    arm_i = 0; step();
    presamples_i = 3; samples_i = 50; arm_i = 1;
    step(8);
    trig_i = 1; step(); trig_i = 0;
    step(10);
    chk("t5_capturing", adc_capture_go_o, 1);
    reset_n = 0; arm_i = 0;
    #1;
    chk("t5_async_go", adc_capture_go_o, 0);
    chk("t5_async_mask", adc_write_mask_o, 0);
    chk("t5_async_data", adc_data_o, 0);
    step(2);
    reset_n = 1;
    step(2);
    base_go = mon_go;
    trig_i = 1; step(); trig_i = 0; step(3);
    chk("t5_not_armed", armed_o, 0);
    chk("t5_not_done", capture_done_o, 0);
    chk("t5_go_cycles", mon_go - base_go, 0);

    // 6: re-arm during capture with simultaneous trigger, new P/N take effect
    presamples_i = 5; samples_i = 30; arm_i = 1;
    step(10);
    trig_i = 1; step(); trig_i = 0;
    step(5);
    arm_i = 0; step();
    presamples_i = 1; samples_i = 3; arm_i = 1; trig_i = 1;
    step();
    chk("t6_rearmed", armed_o, 1);
    chk("t6_go_dropped", adc_capture_go_o, 0);
    chk("t6_not_done", capture_done_o, 0);
    step(); trig_i = 0; step(4);
    chk("t6_still_armed", armed_o, 1);
    base_go = mon_go; base_mask = mon_mask;
    trig_i = 1; tg = cyc;
    step(); trig_i = 0;
    wait_done(200);
    chk("t6_go_cycles", mon_go - base_go, 3);
    chk("t6_valid_beats", mon_mask - base_mask, 3);
    chk("t6_first_data", mon_first, sample_at(tg - 1));
    chk("t6_short", presample_short_o, 0);

    step(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
